// File: rtl/x_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: owns HI/LO, runs MULT/DIV as a
// 32-edge shift-add or restoring-divide loop followed by a sign-fix edge.
module x_muldiv_unit #(
    parameter int         DATA_W   = 32,
    parameter logic [5:0] OP_MFHI  = 6'h10,
    parameter logic [5:0] OP_MTHI  = 6'h11,
    parameter logic [5:0] OP_MFLO  = 6'h12,
    parameter logic [5:0] OP_MTLO  = 6'h13,
    parameter logic [5:0] OP_MULT  = 6'h18,
    parameter logic [5:0] OP_MULTU = 6'h19,
    parameter logic [5:0] OP_DIV   = 6'h1A,
    parameter logic [5:0] OP_DIVU  = 6'h1B
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    input  logic [5:0]        alu_op,
    input  logic [DATA_W-1:0] s1,
    input  logic [DATA_W-1:0] s2,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mf_result
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]     r_opb;
    logic                  r_is_div;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic                  r_dz;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_done;

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v,
                                                input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_dw(input logic [2*DATA_W-1:0] v,
                                                   input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic w_is_mult, w_is_div, w_is_signed, w_is_mf, w_is_mt, w_any_op;
    logic w_idle, w_accept, w_last;

    assign w_is_mult   = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
    assign w_is_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
    assign w_is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign w_is_mf     = (alu_op == OP_MFHI) || (alu_op == OP_MFLO);
    assign w_is_mt     = (alu_op == OP_MTHI) || (alu_op == OP_MTLO);
    assign w_any_op    = w_is_mult | w_is_div | w_is_mf | w_is_mt;
    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = w_idle & enable & ~flush & (w_is_mult | w_is_div);
    assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));

    // Operand magnitudes and result sign flags captured at accept
    logic w_s1_neg, w_s2_neg;
    logic [DATA_W-1:0] w_abs1, w_abs2;

    assign w_s1_neg = w_is_signed & s1[DATA_W-1];
    assign w_s2_neg = w_is_signed & s2[DATA_W-1];
    assign w_abs1   = neg_w(s1, w_s1_neg);
    assign w_abs2   = neg_w(s2, w_s2_neg);

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    logic [DATA_W:0] w_mul_sum;

    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                     + {1'b0, (r_acc[0] ? r_opb : {DATA_W{1'b0}})};

    // Divide step: upper half is the partial remainder, lower half shifts
    // the dividend out and the quotient bits in.
    logic [DATA_W:0] w_div_shift;
    logic [DATA_W:0] w_div_diff;
    logic            w_div_ok;

    assign w_div_shift = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = ~w_div_diff[DATA_W];

    // Sign fix-up. With a zero divisor the remainder ends up holding |s1|,
    // and restoring the dividend's sign gives back s1 exactly.
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;

    assign w_prod = neg_dw(r_acc, r_neg_res);
    assign w_quo  = r_dz ? {DATA_W{1'b1}} : neg_w(r_acc[DATA_W-1:0], r_neg_res);
    assign w_rem  = neg_w(r_acc[2*DATA_W-1:DATA_W], r_neg_rem);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_neg_res <= w_s1_neg ^ w_s2_neg;
                        r_neg_rem <= w_s1_neg;
                        r_dz      <= w_is_div && (s2 == '0);
                        if (w_is_div) begin
                            r_acc   <= {{DATA_W{1'b0}}, w_abs1};
                            r_opb   <= w_abs2;
                            r_state <= ST_DIV;
                        end else begin
                            r_acc   <= {{DATA_W{1'b0}}, w_abs2};
                            r_opb   <= w_abs1;
                            r_state <= ST_MUL;
                        end
                    end else if (enable && !flush) begin
                        if (alu_op == OP_MTHI) r_hi <= s1;
                        if (alu_op == OP_MTLO) r_lo <= s1;
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[DATA_W-1:1]};
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_state <= ST_FIX;
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc[2*DATA_W-1:DATA_W] <= w_div_ok ? w_div_diff[DATA_W-1:0]
                                                             : w_div_shift[DATA_W-1:0];
                        r_acc[DATA_W-1:0]        <= {r_acc[DATA_W-2:0], w_div_ok};
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_state <= ST_FIX;
                    end
                end
                default: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod[DATA_W-1:0];
                        end
                        r_done <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = ~w_idle;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = enable & w_any_op & ~w_idle & ~flush;

    always_comb begin
        mf_result = '0;
        if (alu_op == OP_MFHI) mf_result = r_hi;
        if (alu_op == OP_MFLO) mf_result = r_lo;
    end

endmodule
